// File: rtl/cpu_intr_rdy_ctrl.sv
// cpu_intr_rdy_ctrl: system-side driver of the 6502C nmi/irq/RDY inputs.
// Ports: phi1/rst clock and async reset; nmi_src/irq_src interrupt sources;
//   dma_req/cpu_RW/dma_ack DMA halt handshake; reg_* 4-register bus port;
//   nmi/irq/RDY to the CPU core.
module cpu_intr_rdy_ctrl #(
    parameter int NUM_NMI   = 3,
    parameter int NUM_IRQ   = 8,
    parameter int NMI_PULSE = 2
) (
    input  logic               phi1,
    input  logic               rst,
    input  logic [NUM_NMI-1:0] nmi_src,
    input  logic [NUM_IRQ-1:0] irq_src,
    input  logic               dma_req,
    input  logic               cpu_RW,
    input  logic [1:0]         reg_addr,
    input  logic [7:0]         reg_wdata,
    input  logic               reg_we,
    output logic [7:0]         reg_rdata,
    output logic               nmi,
    output logic               irq,
    output logic               RDY,
    output logic               dma_ack
);

    typedef enum logic [1:0] {
        S_RUN,
        S_WAIT_RD,
        S_HALT,
        S_RELEASE
    } rdy_state_e;

    logic [NUM_NMI-1:0] nmi_hist_q, nmi_en_q, nmi_en_d, nmi_st_q, nmi_st_d;
    logic [NUM_NMI-1:0] nmi_ev;
    logic [NUM_IRQ-1:0] irq_en_q, irq_en_d, irq_st_q, irq_st_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               irq_q, irq_d;
    logic               ack_q, ack_d;
    rdy_state_e         state_q, state_d;

    logic wr_nmien, wr_nmires, wr_irqen;

    assign wr_nmien  = reg_we && (reg_addr == 2'd0);
    assign wr_nmires = reg_we && (reg_addr == 2'd1);
    assign wr_irqen  = reg_we && (reg_addr == 2'd2);

    // Only enabled rising edges count; disabled edges leave no trace.
    assign nmi_ev = nmi_src & ~nmi_hist_q & nmi_en_q;

    always_comb begin
        nmi_en_d = wr_nmien ? reg_wdata[NUM_NMI-1:0] : nmi_en_q;
        // A set in the same cycle as NMIRES survives the clear.
        nmi_st_d = (wr_nmires ? '0 : nmi_st_q) | nmi_ev;
        cnt_d    = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
        // Edges during a running pulse only update status.
        if ((|nmi_ev) && (cnt_q == 4'd0)) begin
            cnt_d = 4'(NMI_PULSE);
        end
    end

    always_comb begin
        irq_en_d = wr_irqen ? reg_wdata[NUM_IRQ-1:0] : irq_en_q;
        // Masking with the new enable makes an IRQEN clear beat a set.
        irq_st_d = (irq_st_q | irq_src) & irq_en_d;
        irq_d    = |(irq_st_d & irq_en_d);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_RUN: begin
                if (dma_req) begin
                    state_d = cpu_RW ? S_HALT : S_WAIT_RD;
                end
            end
            S_WAIT_RD: begin
                if (!dma_req) begin
                    state_d = S_RUN;
                end else if (cpu_RW) begin
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                if (!dma_req) begin
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: state_d = S_RUN;
            default:   state_d = S_RUN;
        endcase
        // Grant follows one cycle after RDY has actually fallen.
        ack_d = (state_q == S_HALT) && (state_d == S_HALT);
    end

    always_ff @(posedge phi1 or posedge rst) begin
        if (rst) begin
            nmi_hist_q <= '1;
            nmi_en_q   <= '0;
            nmi_st_q   <= '0;
            cnt_q      <= 4'd0;
            irq_en_q   <= '0;
            irq_st_q   <= '0;
            irq_q      <= 1'b0;
            ack_q      <= 1'b0;
            state_q    <= S_RUN;
        end else begin
            nmi_hist_q <= nmi_src;
            nmi_en_q   <= nmi_en_d;
            nmi_st_q   <= nmi_st_d;
            cnt_q      <= cnt_d;
            irq_en_q   <= irq_en_d;
            irq_st_q   <= irq_st_d;
            irq_q      <= irq_d;
            ack_q      <= ack_d;
            state_q    <= state_d;
        end
    end

    always_comb begin
        reg_rdata = 8'h00;
        unique case (reg_addr)
            2'd1:    reg_rdata[NUM_NMI-1:0] = nmi_st_q;
            2'd3:    reg_rdata[NUM_IRQ-1:0] = irq_st_q;
            default: reg_rdata = 8'h00;
        endcase
    end

    assign nmi     = (cnt_q != 4'd0);
    assign irq     = irq_q;
    assign RDY     = (state_q != S_HALT);
    assign dma_ack = ack_q;

endmodule

// File: tb/tb_cpu_intr_rdy_ctrl.sv
// tb_cpu_intr_rdy_ctrl: scoreboard bench for cpu_intr_rdy_ctrl.
// Expected output vectors {nmi,irq,RDY,dma_ack} and register reads are queued.
module tb_cpu_intr_rdy_ctrl;

    logic       phi1 = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] nmi_src = '0;
    logic [7:0] irq_src = '0;
    logic       dma_req = 1'b0;
    logic       cpu_RW = 1'b1;
    logic [1:0] reg_addr = '0;
    logic [7:0] reg_wdata = '0;
    logic       reg_we = 1'b0;
    logic [7:0] reg_rdata;
    logic       nmi, irq, RDY, dma_ack;

    int checks = 0;
    int passed = 0;
    logic [3:0] sb_q[$];
    logic [7:0] rd_q[$];
    logic [3:0] eo;
    logic [7:0] er;

    cpu_intr_rdy_ctrl #(.NUM_NMI(3), .NUM_IRQ(8), .NMI_PULSE(2)) dut (
        .phi1(phi1), .rst(rst), .nmi_src(nmi_src), .irq_src(irq_src),
        .dma_req(dma_req), .cpu_RW(cpu_RW), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_rdata(reg_rdata),
        .nmi(nmi), .irq(irq), .RDY(RDY), .dma_ack(dma_ack)
    );

    always #5 phi1 = ~phi1;

    task automatic step();
        @(posedge phi1);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        dma_req = 1'b0;
        cpu_RW = 1'b1;
        reg_we = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        step();
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        reg_addr = a;
        reg_wdata = d;
        reg_we = 1'b1;
        step();
        reg_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        sb_q.push_back(4'b0010);
        rd_q.push_back(8'h00);
        rd_q.push_back(8'h00);
        eo = sb_q.pop_front();
        checks++;
        if ({nmi, irq, RDY, dma_ack} !== eo)
            $display("FAIL reset_out got %b want %b", {nmi, irq, RDY, dma_ack}, eo);
        else passed++;
        for (int a = 1; a < 4; a += 2) begin
            reg_addr = 2'(a);
            #1;
            er = rd_q.pop_front();
            checks++;
            if (reg_rdata !== er)
                $display("FAIL reset_rd%0d got %h want %h", a, reg_rdata, er);
            else passed++;
        end
        do_reset();
    endtask

    task automatic test_nmi_pulse();
        do_reset();
        wr(2'd0, 8'h03);
        nmi_src[1] = 1'b1;
        sb_q.push_back(4'b1010);
        sb_q.push_back(4'b1010);
        sb_q.push_back(4'b0010);
        for (int i = 0; i < 3; i++) begin
            step();
            eo = sb_q.pop_front();
            checks++;
            if ({nmi, irq, RDY, dma_ack} !== eo)
                $display("FAIL nmi_pulse c%0d got %b want %b", i, {nmi, irq, RDY, dma_ack}, eo);
            else passed++;
        end
        rd_q.push_back(8'h02);
        reg_addr = 2'd1;
        #1;
        er = rd_q.pop_front();
        checks++;
        if (reg_rdata !== er)
            $display("FAIL nmist_set got %h want %h", reg_rdata, er);
        else passed++;
        wr(2'd1, 8'h00);
        rd_q.push_back(8'h00);
        reg_addr = 2'd1;
        #1;
        er = rd_q.pop_front();
        checks++;
        if (reg_rdata !== er)
            $display("FAIL nmires got %h want %h", reg_rdata, er);
        else passed++;
        reg_addr = 2'd0;
        #1;
        checks++;
        if (reg_rdata !== 8'h00)
            $display("FAIL nmien_rd got %h want 00", reg_rdata);
        else passed++;
        nmi_src = '0;
    endtask

    task automatic test_nmi_held_merge();
        nmi_src[0] = 1'b1;
        do_reset();
        wr(2'd0, 8'h01);
        sb_q.push_back(4'b0010);
        sb_q.push_back(4'b0010);
        for (int i = 0; i < 2; i++) begin
            step();
            eo = sb_q.pop_front();
            checks++;
            if ({nmi, irq, RDY, dma_ack} !== eo)
                $display("FAIL nmi_held c%0d got %b want %b", i, {nmi, irq, RDY, dma_ack}, eo);
            else passed++;
        end
        // low, high, low, high: second edge lands inside the pulse
        for (int i = 0; i < 5; i++) begin
            nmi_src[0] = (i % 2 == 1);
            sb_q.push_back((i == 1 || i == 2) ? 4'b1010 : 4'b0010);
            step();
            eo = sb_q.pop_front();
            checks++;
            if ({nmi, irq, RDY, dma_ack} !== eo)
                $display("FAIL nmi_merge c%0d got %b want %b", i, {nmi, irq, RDY, dma_ack}, eo);
            else passed++;
        end
        rd_q.push_back(8'h01);
        reg_addr = 2'd1;
        #1;
        er = rd_q.pop_front();
        checks++;
        if (reg_rdata !== er)
            $display("FAIL nmist_merge got %h want %h", reg_rdata, er);
        else passed++;
        nmi_src = '0;
    endtask

    task automatic test_irq();
        do_reset();
        wr(2'd2, 8'h81);
        irq_src[7] = 1'b1;
        irq_src[3] = 1'b1;
        sb_q.push_back(4'b0110);
        rd_q.push_back(8'h80);
        step();
        eo = sb_q.pop_front();
        checks++;
        if ({nmi, irq, RDY, dma_ack} !== eo)
            $display("FAIL irq_rise got %b want %b", {nmi, irq, RDY, dma_ack}, eo);
        else passed++;
        reg_addr = 2'd3;
        #1;
        er = rd_q.pop_front();
        checks++;
        if (reg_rdata !== er)
            $display("FAIL irqst_set got %h want %h", reg_rdata, er);
        else passed++;
        irq_src = '0;
        sb_q.push_back(4'b0110);
        step();
        eo = sb_q.pop_front();
        checks++;
        if ({nmi, irq, RDY, dma_ack} !== eo)
            $display("FAIL irq_hold got %b want %b", {nmi, irq, RDY, dma_ack}, eo);
        else passed++;
        // clear of bit 7 coincides with the source rising again
        irq_src[7] = 1'b1;
        sb_q.push_back(4'b0010);
        rd_q.push_back(8'h00);
        wr(2'd2, 8'h01);
        eo = sb_q.pop_front();
        checks++;
        if ({nmi, irq, RDY, dma_ack} !== eo)
            $display("FAIL irq_clear got %b want %b", {nmi, irq, RDY, dma_ack}, eo);
        else passed++;
        reg_addr = 2'd3;
        #1;
        er = rd_q.pop_front();
        checks++;
        if (reg_rdata !== er)
            $display("FAIL irqst_clear got %h want %h", reg_rdata, er);
        else passed++;
        irq_src = 8'h01;
        sb_q.push_back(4'b0110);
        rd_q.push_back(8'h01);
        step();
        irq_src = '0;
        eo = sb_q.pop_front();
        checks++;
        if ({nmi, irq, RDY, dma_ack} !== eo)
            $display("FAIL irq_bit0 got %b want %b", {nmi, irq, RDY, dma_ack}, eo);
        else passed++;
        reg_addr = 2'd3;
        #1;
        er = rd_q.pop_front();
        checks++;
        if (reg_rdata !== er)
            $display("FAIL irqst_bit0 got %h want %h", reg_rdata, er);
        else passed++;
    endtask

    task automatic test_dma_wait_rd();
        logic [2:0] rw_seq[10] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
        logic       rq_seq[10] = '{1, 1, 1, 1, 1, 1, 0, 1, 1, 0};
        logic [3:0] ex_seq[10] = '{4'b0010, 4'b0010, 4'b0010, 4'b0000,
                                   4'b0001, 4'b0001, 4'b0010, 4'b0010,
                                   4'b0000, 4'b0010};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            dma_req = rq_seq[i];
            cpu_RW = rw_seq[i][0];
            sb_q.push_back(ex_seq[i]);
            step();
            eo = sb_q.pop_front();
            checks++;
            if ({nmi, irq, RDY, dma_ack} !== eo)
                $display("FAIL dma_wr_rd c%0d got %b want %b", i, {nmi, irq, RDY, dma_ack}, eo);
            else passed++;
        end
        dma_req = 1'b0;
        step();
    endtask

    task automatic test_dma_early_drop();
        logic       rw_seq[6] = '{1, 1, 1, 0, 1, 1};
        logic       rq_seq[6] = '{1, 0, 0, 1, 0, 0};
        logic [3:0] ex_seq[6] = '{4'b0000, 4'b0010, 4'b0010,
                                  4'b0010, 4'b0010, 4'b0010};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            dma_req = rq_seq[i];
            cpu_RW = rw_seq[i];
            sb_q.push_back(ex_seq[i]);
            step();
            eo = sb_q.pop_front();
            checks++;
            if ({nmi, irq, RDY, dma_ack} !== eo)
                $display("FAIL dma_drop c%0d got %b want %b", i, {nmi, irq, RDY, dma_ack}, eo);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_halt();
        do_reset();
        wr(2'd2, 8'h01);
        wr(2'd0, 8'h01);
        irq_src[0] = 1'b1;
        nmi_src[0] = 1'b1;
        dma_req = 1'b1;
        cpu_RW = 1'b1;
        sb_q.push_back(4'b1100);
        sb_q.push_back(4'b1101);
        for (int i = 0; i < 2; i++) begin
            step();
            irq_src = '0;
            eo = sb_q.pop_front();
            checks++;
            if ({nmi, irq, RDY, dma_ack} !== eo)
                $display("FAIL halt_pre c%0d got %b want %b", i, {nmi, irq, RDY, dma_ack}, eo);
            else passed++;
        end
        rst = 1'b1;
        #1;
        sb_q.push_back(4'b0010);
        eo = sb_q.pop_front();
        checks++;
        if ({nmi, irq, RDY, dma_ack} !== eo)
            $display("FAIL rst_halt got %b want %b", {nmi, irq, RDY, dma_ack}, eo);
        else passed++;
        for (int a = 1; a < 4; a += 2) begin
            rd_q.push_back(8'h00);
            reg_addr = 2'(a);
            #1;
            er = rd_q.pop_front();
            checks++;
            if (reg_rdata !== er)
                $display("FAIL rst_halt_rd%0d got %h want %h", a, reg_rdata, er);
            else passed++;
        end
        nmi_src = '0;
        do_reset();
    endtask

    task automatic test_nmi_in_halt();
        logic [3:0] ex_seq[5] = '{4'b0000, 4'b0001, 4'b1001, 4'b1001, 4'b0001};
        do_reset();
        wr(2'd0, 8'h04);
        dma_req = 1'b1;
        cpu_RW = 1'b1;
        for (int i = 0; i < 5; i++) begin
            nmi_src[2] = (i >= 2);
            sb_q.push_back(ex_seq[i]);
            step();
            eo = sb_q.pop_front();
            checks++;
            if ({nmi, irq, RDY, dma_ack} !== eo)
                $display("FAIL nmi_halt c%0d got %b want %b", i, {nmi, irq, RDY, dma_ack}, eo);
            else passed++;
        end
        rd_q.push_back(8'h04);
        reg_addr = 2'd1;
        #1;
        er = rd_q.pop_front();
        checks++;
        if (reg_rdata !== er)
            $display("FAIL nmist_halt got %h want %h", reg_rdata, er);
        else passed++;
        dma_req = 1'b0;
        nmi_src = '0;
        step();
    endtask

    initial begin
        test_reset();
        test_nmi_pulse();
        test_nmi_held_merge();
        test_irq();
        test_dma_wait_rd();
        test_dma_early_drop();
        test_reset_mid_halt();
        test_nmi_in_halt();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/cpu_intr_rdy_ctrl.md
Name: cpu_intr_rdy_ctrl

Overview:
- Drives the 6502C core's `nmi`, `irq` and `RDY` inputs from the system side, i.e. the other end of the plaFSM interrupt/ready interface.
- Edge-detects and latches NMI sources (DLI, VBI, RESET key) and level IRQ sources (POKEY-style).
- Arbitrates DMA halt requests into a legal RDY stall. RDY may only stall on a CPU read cycle.
- A small 4-register bus interface provides enables, status readback and clears.

Parameters:
- NUM_NMI, 3, number of NMI sources (1..8).
- NUM_IRQ, 8, number of IRQ sources (1..8).
- NMI_PULSE, 2, cycles the `nmi` output stays high per event (1..15).

Ports:
- phi1  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous active-high reset.
- nmi_src  in  NUM_NMI  NMI request lines; rising edge = event.
- irq_src  in  NUM_IRQ  IRQ request lines; level.
- dma_req  in  1  DMA engine requests CPU halt; held until done.
- cpu_RW  in  1  CPU cycle type this cycle: 1 = read, 0 = write.
- reg_addr  in  2  register select.
- reg_wdata  in  8  write data.
- reg_we  in  1  write strobe, one cycle.
- reg_rdata  out  8  combinational read data.
- nmi  out  1  to CPU, active-high pulse.
- irq  out  1  to CPU, active-high level.
- RDY  out  1  to CPU; 0 = stall.
- dma_ack  out  1  CPU bus granted to DMA.

Behaviour:
- Reset (async, rst=1):
  - Outputs: nmi=0, irq=0, RDY=1, dma_ack=0.
  - Registers: nmi_en, nmi_st, irq_en, irq_st = 0; pulse counter = 0; FSM = RUN.
  - Edge-detect history regs reset to all-ones, so a source already high at reset exit is not an edge.
- Registers:
  - addr0: NMIEN, write-only.
  - addr1: read NMIST, write NMIRES (any write clears all nmi_st).
  - addr2: IRQEN, write-only; writing 0 to bit i also clears irq_st[i].
  - addr3: IRQST, read.
  - Unused upper bits write-ignored, read 0. Reads of addr0 and addr2 return 0.
- NMI path:
  - Edge on source i means nmi_src[i]=1 now and history[i]=0.
  - Edge with nmi_en[i]=1 sets nmi_st[i] and, if the pulse counter is 0, loads it with NMI_PULSE.
  - nmi = (counter != 0), registered; it rises the cycle after the edge is sampled. The counter decrements each cycle.
  - Edges during an active pulse set status only and are merged; no extra pulse.
  - Edge with nmi_en[i]=0: ignored entirely.
  - NMIRES in the same cycle as an edge: the set wins.
- IRQ path:
  - irq_st[i] sets on any cycle where irq_src[i]=1 and irq_en[i]=1.
  - irq = |(irq_st & irq_en), registered, one cycle latency.
  - IRQEN clear and source set in the same cycle: the clear wins, since the enable is now 0.
- RDY FSM:
  - RUN: RDY=1. If dma_req=1 and cpu_RW=1, go to HALT; if dma_req=1 and cpu_RW=0, go to WAIT_RD.
  - WAIT_RD: RDY=1. Go to HALT on the first cycle with cpu_RW=1. If dma_req drops, return to RUN. Up to 3 consecutive 6502 write cycles must be tolerated; there is no timeout.
  - HALT: RDY=0. dma_ack=1 from the second HALT cycle onward, one cycle after RDY falls. Stays while dma_req=1. If dma_req=0, go to RELEASE.
  - RELEASE: RDY=1, dma_ack=0 for exactly one cycle, then RUN. A dma_req reasserted during RELEASE is evaluated in RUN on the next cycle.
  - Outputs are registered from the state; RDY falls the cycle after the qualifying read.
  - dma_req dropping before dma_ack asserts (first HALT cycle) still goes to RELEASE.
- Independence: the NMI and IRQ paths keep operating during HALT; their outputs are not gated by RDY.
- Reset mid-HALT: RDY=1 and dma_ack=0 immediately (async); the DMA engine must re-request.

Test Plan:
1. Reset, then NMIEN=0x03; pulse nmi_src[1] 0→1 → nmi high for exactly 2 cycles starting 1 cycle after the edge; NMIST reads 0x02; write NMIRES → reads 0x00.
2. nmi_src[0] held high through reset release, NMIEN=0x01 → no nmi pulse. Then nmi_src[0] low→high twice 1 cycle apart → a single 2-cycle pulse; NMIST=0x01.
3. IRQEN=0x81; raise irq_src[7] → irq=1 next cycle, IRQST=0x80. Lower the source → irq stays 1. Write IRQEN=0x01 → IRQST=0x00, irq=0 next cycle.
4. dma_req=1 while cpu_RW=0 for 3 cycles then 1 → RDY stays 1 through the writes, falls 1 cycle after the read, dma_ack rises 1 cycle later. Drop dma_req → RDY=1, dma_ack=0 next cycle, RUN after one RELEASE cycle.
5. dma_req=1 during a read → HALT. Assert rst mid-HALT → RDY=1, dma_ack=0 asynchronously, all status 0.
6. While in HALT with NMIEN=0x04, edge on nmi_src[2] → nmi pulses normally with RDY=0; NMIST=0x04.
